serial_mag_compare: RTL and testbench

//  Multi-cycle unsigned magnitude comparator for WIDTH-bit operands. Latches a/b on

---
 rtl/serial_mag_compare.sv | 126 ++++++++++++
 tb/tb_serial_mag_compare.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_compare.sv
// Multi-cycle unsigned magnitude comparator: walks 2-bit digit pairs MSB-first
// through the combinational `comparator` cell and stops on the first unequal digit.

module comparator (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       eq,
  output logic       le,
  output logic       gt
);

  // le is strictly "x less than y".
  assign eq = (x == y);
  assign le = (x <  y);
  assign gt = (x >  y);

endmodule

module serial_mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int NDIG  = WIDTH / 2;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ra, rb;
  logic [IDX_W-1:0] idx;
  logic [1:0]       dig_a, dig_b;
  logic             cell_eq, cell_le, cell_gt;
  logic             accept, last_dig, decided;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IDX_W'(k)) begin
        dig_a = ra[2*k +: 2];
        dig_b = rb[2*k +: 2];
      end
    end
  end

  comparator u_cell (
    .x  (dig_a),
    .y  (dig_b),
    .eq (cell_eq),
    .le (cell_le),
    .gt (cell_gt)
  );

  assign accept   = start && (state != RUN);
  assign last_dig = (idx == '0);
  assign decided  = cell_gt || cell_le || (cell_eq && last_dig);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = RUN;
      RUN:     if (decided) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: ra/rb are deliberately left out of reset; they are only read in RUN,
  // which is always entered through a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      ra <= a;
      rb <= b;
    end
  end

  // NOTE: state is written with non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx <= IDX_W'(NDIG - 1);
        eq  <= 1'b0;
        lt  <= 1'b0;
        gt  <= 1'b0;
      end else if (state == RUN) begin
        if (cell_gt)
          gt <= 1'b1;
        else if (cell_le)
          lt <= 1'b1;
        else if (cell_eq && last_dig)
          eq <= 1'b1;
        else
          idx <= idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench: WIDTH=2/4/8 instances against a digit-scan timing model
// and plain arithmetic compare results.

module tb_serial_mag_compare;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s2, s4, s8;
  logic [1:0] a2, b2;
  logic [3:0] a4, b4;
  logic [7:0] a8, b8;
  logic       busy2, done2, eq2, lt2, gt2;
  logic       busy4, done4, eq4, lt4, gt4;
  logic       busy8, done8, eq8, lt8, gt8;

  int checks = 0;
  int errors = 0;
  int done_cnt2 = 0, done_cnt4 = 0, done_cnt8 = 0;
  int exp_done2 = 0, exp_done4 = 0, exp_done8 = 0;
  int excl_err = 0;

  always #5 clk = ~clk;

  serial_mag_compare #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .eq(eq2), .lt(lt2), .gt(gt2));
  serial_mag_compare #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .eq(eq4), .lt(lt4), .gt(gt4));
  serial_mag_compare #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .eq(eq8), .lt(lt8), .gt(gt8));

  // Done pulses and one-hot/busy-done exclusivity are tallied every cycle.
  always @(negedge clk) begin
    if (done2 === 1'b1) done_cnt2 <= done_cnt2 + 1;
    if (done4 === 1'b1) done_cnt4 <= done_cnt4 + 1;
    if (done8 === 1'b1) done_cnt8 <= done_cnt8 + 1;
    if (int'(eq2 === 1'b1) + int'(lt2 === 1'b1) + int'(gt2 === 1'b1) > 1 ||
        int'(eq4 === 1'b1) + int'(lt4 === 1'b1) + int'(gt4 === 1'b1) > 1 ||
        int'(eq8 === 1'b1) + int'(lt8 === 1'b1) + int'(gt8 === 1'b1) > 1 ||
        (busy2 === 1'b1 && done2 === 1'b1) ||
        (busy4 === 1'b1 && done4 === 1'b1) ||
        (busy8 === 1'b1 && done8 === 1'b1))
      excl_err <= excl_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] obs(input int w);
    case (w)
      2:       return {busy2, done2, eq2, lt2, gt2};
      4:       return {busy4, done4, eq4, lt4, gt4};
      default: return {busy8, done8, eq8, lt8, gt8};
    endcase
  endfunction

  task automatic drv(input int w, input logic s, input logic [7:0] av, input logic [7:0] bv);
    case (w)
      2:       begin s2 = s; a2 = av[1:0]; b2 = bv[1:0]; end
      4:       begin s4 = s; a4 = av[3:0]; b4 = bv[3:0]; end
      default: begin s8 = s; a8 = av;      b8 = bv;      end
    endcase
  endtask

  task automatic st(input int w, input logic s);
    case (w)
      2:       s2 = s;
      4:       s4 = s;
      default: s8 = s;
    endcase
  endtask

  task automatic bump_done(input int w);
    case (w)
      2:       exp_done2++;
      4:       exp_done4++;
      default: exp_done8++;
    endcase
  endtask

  // Index (0 = MSB digit) of the digit that decides the compare.
  function automatic int dec_digit(input int w, input int av, input int bv);
    for (int j = 0; j < w / 2; j++) begin
      int sh = w - 2 - 2 * j;
      if (((av >> sh) & 3) != ((bv >> sh) & 3)) return j;
    end
    return w / 2 - 1;
  endfunction

  // Called at posedge+1 with the DUT idle or in DONE. With chain=1 the next
  // start is driven in this compare's DONE cycle and the task returns there.
  task automatic run_cmp(input int w, input logic [7:0] av, input logic [7:0] bv,
                         input bit chain, input logic [7:0] nav, input logic [7:0] nbv,
                         input bit poke);
    int         dc;
    logic [2:0] exp_res;
    logic [4:0] o;
    string      id;
    dc      = 2 + dec_digit(w, int'(av), int'(bv));
    exp_res = {av == bv, av < bv, av > bv};
    id      = $sformatf("w%0d a=%h b=%h", w, av, bv);
    drv(w, 1'b1, av, bv);
    @(posedge clk); #1;
    st(w, 1'b0);
    for (int c = 1; c <= dc; c++) begin
      if (poke && c == 1) drv(w, 1'b1, 8'h11, 8'h11);
      if (poke && c == 2) st(w, 1'b0);
      if (chain && c == dc) drv(w, 1'b1, nav, nbv);
      @(negedge clk);
      o = obs(w);
      check($sformatf("%s c%0d busy_done", id, c), 32'(o[4:3]), {30'd0, c < dc, c == dc});
      if (c == dc)
        check($sformatf("%s result", id), 32'(o[2:0]), 32'(exp_res));
      else
        check($sformatf("%s c%0d cleared", id, c), 32'(o[2:0]), 32'd0);
      if (c < dc) begin
        @(posedge clk); #1;
      end
    end
    bump_done(w);
    if (!chain) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("%s idle_hold", id), 32'(obs(w)), {27'd0, 2'b00, exp_res});
      @(posedge clk); #1;
    end
  endtask

  task automatic sweep(input int w);
    int n = 1 << (2 * w);
    for (int i = 0; i < n; i++) begin
      logic [7:0] av, bv, nav, nbv;
      bit ch;
      av  = 8'(i >> w);
      bv  = 8'(i & ((1 << w) - 1));
      nav = 8'((i + 1) >> w);
      nbv = 8'((i + 1) & ((1 << w) - 1));
      ch  = (i < n - 1) && ($urandom_range(0, 1) == 1);
      run_cmp(w, av, bv, ch, nav, nbv, 1'b0);
    end
  endtask

  function automatic logic [7:0] rand_b(input logic [7:0] av);
    case ($urandom_range(0, 2))
      0:       return 8'($urandom);
      1:       return av ^ (8'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
      default: return av;
    endcase
  endfunction

  initial begin
    logic [7:0] ca, cb, na, nb;
    bit ch;
    rst_n = 1'b0;
    drv(2, 1'b0, 8'h00, 8'h00);
    drv(4, 1'b0, 8'h00, 8'h00);
    drv(8, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    @(negedge clk);
    check("reset w2", 32'(obs(2)), 32'd0);
    check("reset w4", 32'(obs(4)), 32'd0);
    check("reset w8", 32'(obs(8)), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmp(8, 8'hA5, 8'hA5, 1'b0, 8'h00, 8'h00, 1'b0);
    run_cmp(8, 8'h80, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b0);
    run_cmp(8, 8'h34, 8'h37, 1'b0, 8'h00, 8'h00, 1'b0);
    run_cmp(8, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1);
    run_cmp(8, 8'h12, 8'h13, 1'b1, 8'hF0, 8'hF0, 1'b0);
    run_cmp(8, 8'hF0, 8'hF0, 1'b1, 8'hC3, 8'h03, 1'b0);
    run_cmp(8, 8'hC3, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset in cycle 2 of an all-equal compare aborts it with no done pulse.
    drv(8, 1'b1, 8'h5A, 8'h5A);
    @(posedge clk); #1;
    st(8, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort c2 busy", 32'(obs(8)), 32'b10000);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort c3 idle", 32'(obs(8)), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort after", 32'(obs(8)), 32'd0);
    check("abort ndone8", 32'(done_cnt8), 32'(exp_done8));
    @(posedge clk); #1;

    ca = 8'($urandom);
    cb = rand_b(ca);
    for (int i = 0; i < 300; i++) begin
      na = 8'($urandom);
      nb = rand_b(na);
      ch = (i < 299) && ($urandom_range(0, 1) == 1);
      run_cmp(8, ca, cb, ch, na, nb, 1'b0);
      ca = na;
      cb = nb;
    end

    sweep(2);
    sweep(4);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ndone2", 32'(done_cnt2), 32'(exp_done2));
    check("ndone4", 32'(done_cnt4), 32'(exp_done4));
    check("ndone8", 32'(done_cnt8), 32'(exp_done8));
    check("exclusive", 32'(excl_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
